// File: rtl/fsm_ksa_shuffle_if.sv
// fsm_ksa_shuffle_if
//   Handshake and S-RAM bus of the RC4 KSA swap stage.
//   master : controller/RAM side (drives start, ack, key, RAM read data)
//   slave  : KSA stage side (drives RAM address/data/wren and finish)
//   In_Start       start request (level)
//   Finish_ack     acknowledge of Shuffle_Finish
//   secret_key     key, byte 0 in the MSBs
//   q              S-RAM read data
//   Address, data, wren  S-RAM port
//   Shuffle_Finish high while the stage is done
interface fsm_ksa_shuffle_if #(
    parameter int KEY_LEN = 3
);
    logic                   In_Start;
    logic                   Finish_ack;
    logic [8*KEY_LEN-1:0]   secret_key;
    logic [7:0]             q;
    logic [7:0]             Address;
    logic [7:0]             data;
    logic                   wren;
    logic                   Shuffle_Finish;

    modport master (
        output In_Start, Finish_ack, secret_key, q,
        input  Address, data, wren, Shuffle_Finish
    );

    modport slave (
        input  In_Start, Finish_ack, secret_key, q,
        output Address, data, wren, Shuffle_Finish
    );
endinterface

// File: rtl/fsm_ksa_shuffle.sv
// fsm_ksa_shuffle
//   RC4 key-scheduling swap stage. After the init stage has left S[i]=i in
//   the 256x8 S-RAM, runs i=0..255: j += S[i] + key[i mod KEY_LEN], then
//   swaps S[i] and S[j] through the shared RAM port (2-edge read latency).
//   Each iteration is 9 edges; the run is 2304 edges after the start edge.
// Ports
//   CLOCK_50  sole clock, rising edge
//   rst_n     asynchronous active-low reset; aborts a run at once
//   bus       fsm_ksa_shuffle_if.slave (start/ack/key/q in, RAM port and
//             Shuffle_Finish out; all outputs registered)
// Configuration
//   KSA_SKIP_SELF_SWAP_EN : when defined, an iteration with i==j skips both
//   writes and saves 2 edges.
module fsm_ksa_shuffle #(
    parameter int KEY_LEN = 3,
    parameter int ADDR_W  = 8
) (
    input  logic               CLOCK_50,
    input  logic               rst_n,
    fsm_ksa_shuffle_if.slave   bus
);
    localparam int KW = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;

    generate
        if (ADDR_W != 8) begin : g_bad_addr_w
            $error("fsm_ksa_shuffle: ADDR_W must be 8");
        end
    endgenerate

    typedef enum logic [3:0] {
        IDLE, RD_I, WAIT_I, CALC_J, RD_J, WAIT_J, LAT_J, WR_I, WR_J, NEXT, DONE
    } state_t;

    state_t               state;
    logic [ADDR_W-1:0]    i, j;
    logic [7:0]           si, sj;
    logic [8*KEY_LEN-1:0] key_q;
    logic [KW-1:0]        kidx;   // i mod KEY_LEN, wraps instead of dividing

    logic [7:0] key_bytes [KEY_LEN];
    logic [7:0] key_byte;
    logic [7:0] j_next;

    // Byte 0 lives in the MSBs of the key word.
    generate
        for (genvar g = 0; g < KEY_LEN; g++) begin : g_kb
            assign key_bytes[g] = key_q[8*(KEY_LEN-g)-1 -: 8];
        end
    endgenerate

    assign key_byte = key_bytes[kidx];
    assign j_next   = j + bus.q + key_byte;

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            i                  <= '0;
            j                  <= '0;
            si                 <= '0;
            sj                 <= '0;
            key_q              <= '0;
            kidx               <= '0;
            bus.Address        <= '0;
            bus.data           <= '0;
            bus.wren           <= 1'b0;
            bus.Shuffle_Finish <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.In_Start) begin
                        key_q       <= bus.secret_key;
                        i           <= '0;
                        j           <= '0;
                        kidx        <= '0;
                        bus.Address <= '0;
                        bus.wren    <= 1'b0;
                        state       <= RD_I;
                    end
                end
                RD_I:   state <= WAIT_I;
                WAIT_I: state <= CALC_J;
                CALC_J: begin
                    // q now holds S[i]; address of RD_J is the new j.
                    si          <= bus.q;
                    j           <= j_next;
                    bus.Address <= j_next;
                    state       <= RD_J;
                end
                RD_J:   state <= WAIT_J;
                WAIT_J: state <= LAT_J;
                LAT_J: begin
                    sj <= bus.q;
`ifdef KSA_SKIP_SELF_SWAP_EN
                    if (i == j) begin
                        state <= NEXT;
                    end else begin
                        bus.Address <= i;
                        bus.data    <= bus.q;
                        bus.wren    <= 1'b1;
                        state       <= WR_I;
                    end
`else
                    bus.Address <= i;
                    bus.data    <= bus.q;
                    bus.wren    <= 1'b1;
                    state       <= WR_I;
`endif
                end
                WR_I: begin
                    bus.Address <= j;
                    bus.data    <= si;
                    state       <= WR_J;
                end
                WR_J: begin
                    bus.wren <= 1'b0;
                    state    <= NEXT;
                end
                NEXT: begin
                    if (i == '1) begin
                        bus.Shuffle_Finish <= 1'b1;
                        state              <= DONE;
                    end else begin
                        i           <= i + 1'b1;
                        kidx        <= (kidx == KW'(KEY_LEN-1)) ? '0 : kidx + 1'b1;
                        bus.Address <= i + 1'b1;
                        state       <= RD_I;
                    end
                end
                DONE: begin
                    if (bus.Finish_ack) begin
                        bus.Shuffle_Finish <= 1'b0;
                        state              <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fsm_ksa_shuffle.sv
// tb_fsm_ksa_shuffle
//   Random-key KSA runs against a plain RC4 key-schedule model. Each run's
//   expected RAM writes go into a queue; a monitor pops one per observed
//   wren. Also checks reset values, finish latency, ack handling, final RAM
//   contents and a mid-run asynchronous reset.
module tb_fsm_ksa_shuffle;
    localparam int KEY_LEN = 3;
`ifdef KSA_SKIP_SELF_SWAP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic CLOCK_50 = 1'b0;
    logic rst_n    = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    fsm_ksa_shuffle_if #(.KEY_LEN(KEY_LEN)) bus ();

    fsm_ksa_shuffle #(.KEY_LEN(KEY_LEN), .ADDR_W(8)) dut (
        .CLOCK_50 (CLOCK_50),
        .rst_n    (rst_n),
        .bus      (bus)
    );

    // S-RAM model: address registered, data registered -> 2-edge read.
    logic [7:0] mem [256];
    logic [7:0] img [256];
    logic       ram_load = 1'b0;
    logic [7:0] addr_r, q_r;
    always @(posedge CLOCK_50) begin
        if (ram_load) begin
            for (int k = 0; k < 256; k++) mem[k] <= img[k];
        end else if (bus.wren) begin
            mem[bus.Address] <= bus.data;
        end
        addr_r <= bus.Address;
        q_r    <= mem[addr_r];
    end
    assign bus.q = q_r;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
        int         it;
        bit         wi;
    } wr_t;

    wr_t  exp_q [$];
    int   vectors    = 0;
    int   miscompares = 0;
    int   wr_seen    = 0;
    bit   arm_abort  = 1'b0;
    bit   abort_hit  = 1'b0;

    logic [7:0] s_m [256];
    int         j_at [256];
    int         nself;

    task automatic chk(input string name, input longint got, input longint exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    // Monitor: every write the DUT presents must be the next expected one.
    always @(negedge CLOCK_50) begin
        wr_t e;
        if (rst_n && bus.wren === 1'b1) begin
            wr_seen++;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL wr_unexpected got addr=%h data=%h expected no write",
                         bus.Address, bus.data);
            end else begin
                e = exp_q.pop_front();
                if (bus.Address !== e.a || bus.data !== e.d) begin
                    miscompares++;
                    $display("FAIL wr_iter%0d_%s got addr=%h data=%h expected addr=%h data=%h",
                             e.it, e.wi ? "i" : "j", bus.Address, bus.data, e.a, e.d);
                end
                if (arm_abort && e.it == 100 && e.wi) abort_hit = 1'b1;
            end
        end
    end

    // Plain RC4 key schedule on s_m for n_iter iterations.
    task automatic model_run(input logic [8*KEY_LEN-1:0] key, input int n_iter, input bit push);
        int         j;
        int         kb;
        logic [7:0] t;
        logic [8*KEY_LEN-1:0] sh;
        j     = 0;
        nself = 0;
        for (int i = 0; i < n_iter; i++) begin
            sh = key >> (8 * (KEY_LEN - 1 - (i % KEY_LEN)));
            kb = int'(sh[7:0]);
            j  = (j + int'(s_m[i]) + kb) % 256;
            j_at[i] = j;
            if (i == j) nself++;
            if (push && !(SKIP && i == j)) begin
                exp_q.push_back('{a: 8'(i), d: s_m[j], it: i, wi: 1'b1});
                exp_q.push_back('{a: 8'(j), d: s_m[i], it: i, wi: 1'b0});
            end
            t      = s_m[i];
            s_m[i] = s_m[j];
            s_m[j] = t;
        end
    endtask

    task automatic load_ram();
        for (int k = 0; k < 256; k++) s_m[k] = img[k];
        @(negedge CLOCK_50) ram_load = 1'b1;
        @(negedge CLOCK_50) ram_load = 1'b0;
    endtask

    task automatic check_ram(input string name);
        int bad;
        bad = 0;
        for (int k = 0; k < 256; k++)
            if (mem[k] !== s_m[k]) begin
                if (bad < 4) $display("FAIL %s[%0d] got=%h expected=%h", name, k, mem[k], s_m[k]);
                bad++;
            end
        vectors++;
        if (bad != 0) miscompares++;
    endtask

    task automatic start_pulse(input logic [8*KEY_LEN-1:0] key);
        @(negedge CLOCK_50);
        bus.secret_key = key;
        bus.In_Start   = 1'b1;
        @(posedge CLOCK_50);
        #1 bus.In_Start = 1'b0;
    endtask

    // Full run from the contents currently in s_m/mem.
    task automatic do_run(input logic [8*KEY_LEN-1:0] key, input bit toggle, input int ack_delay);
        int cnt, exp_lat, wr0, exp_wr;
        model_run(key, 256, 1'b1);
        exp_lat = 2304 - (SKIP ? 2 * nself : 0);
        exp_wr  = SKIP ? 2 * (256 - nself) : 512;
        wr0     = wr_seen;
        start_pulse(key);
        cnt = 0;
        while (cnt < 3000) begin
            @(posedge CLOCK_50);
            cnt++;
            #1;
            if (bus.Shuffle_Finish === 1'b1) break;
            if (toggle) begin
                bus.In_Start   = 1'($urandom);
                bus.Finish_ack = 1'($urandom);
            end
        end
        bus.In_Start   = 1'b0;
        bus.Finish_ack = 1'b0;
        chk("finish_latency", cnt, exp_lat);
        for (int k = 0; k < ack_delay; k++) begin
            @(posedge CLOCK_50);
            #1 chk("finish_held", bus.Shuffle_Finish, 1);
        end
        @(negedge CLOCK_50) bus.Finish_ack = 1'b1;
        @(posedge CLOCK_50);
        #1 bus.Finish_ack = 1'b0;
        chk("finish_clear", bus.Shuffle_Finish, 0);
        chk("writes_pending", exp_q.size(), 0);
        chk("wren_count", wr_seen - wr0, exp_wr);
        repeat (3) @(posedge CLOCK_50);
        #1 chk("idle_wren", bus.wren, 0);
        check_ram("ram");
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8*KEY_LEN-1:0] key;
        int                   w;

        bus.In_Start   = 1'b0;
        bus.Finish_ack = 1'b0;
        bus.secret_key = '0;

        // Reset values.
        #22;
        chk("rst_addr", bus.Address, 0);
        chk("rst_data", bus.data, 0);
        chk("rst_wren", bus.wren, 0);
        chk("rst_finish", bus.Shuffle_Finish, 0);
        #1 rst_n = 1'b1;

        // Identity RAM, zero key: i=0,1 are self-swaps, i=2 swaps with 3.
        for (int k = 0; k < 256; k++) img[k] = 8'(k);
        load_ram();
        do_run('0, 1'b0, 0);

        // Identity RAM, key 010203, with start/ack noise during the run.
        for (int k = 0; k < 256; k++) img[k] = 8'(k);
        load_ram();
        do_run(24'h010203, 1'b1, 10);

        // Abort during WR_I of iteration 100.
        for (int k = 0; k < 256; k++) img[k] = 8'(k);
        do begin
            key = 24'($urandom);
            for (int k = 0; k < 256; k++) s_m[k] = img[k];
            model_run(key, 101, 1'b0);
        end while (SKIP && j_at[100] == 100);
        load_ram();
        model_run(key, 256, 1'b1);
        arm_abort = 1'b1;
        abort_hit = 1'b0;
        start_pulse(key);
        w = 0;
        while (w < 2000 && !abort_hit) begin
            @(negedge CLOCK_50);
            #1 w++;
        end
        chk("abort_reached", abort_hit, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_wren_async", bus.wren, 0);
        chk("abort_addr", bus.Address, 0);
        chk("abort_finish", bus.Shuffle_Finish, 0);
        arm_abort = 1'b0;
        exp_q.delete();
        @(posedge CLOCK_50);
        @(posedge CLOCK_50);
        #2 rst_n = 1'b1;
        for (int k = 0; k < 256; k++) s_m[k] = img[k];
        model_run(key, 100, 1'b0);
        check_ram("abort_ram");
        // Restart from i=0, j=0 on the partially shuffled RAM.
        do_run(24'($urandom), 1'b0, 0);

        // Random RAM images and keys.
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 256; k++) img[k] = 8'($urandom);
            load_ram();
            do_run(24'($urandom), 1'b0, r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
